// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU and its UART program loader.
package cpu_pkg;

    localparam int CLKS_PER_BIT_DEF = 24;
    localparam int MEM_DEPTH        = 32;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_LDA = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_STA = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } cpu_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } uart_state_e;

    // New accumulator value for the opcodes that write A; others keep it.
    function automatic logic [7:0] alu_result(input logic [2:0] op,
                                              input logic [7:0] acc,
                                              input logic [7:0] mem,
                                              input logic [4:0] imm);
        logic [7:0] r;
        r = acc;
        case (op)
            OP_LDA:  r = mem;
            OP_ADD:  r = acc + mem;
            OP_SUB:  r = acc - mem;
            OP_AND:  r = acc & mem;
            OP_LDI:  r = {3'b000, imm};
            default: r = acc;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_uart_rx.sv
// 8N1 UART receiver, LSB first, with mid-bit sampling and a sticky frame-error flag.
module uart_rx
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       RX,
    output logic [7:0] data,
    output logic       valid,
    output logic       fe
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q;
    logic          rx_meta_q;
    logic          rx_sync_q;
    logic          rx_prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          fe_q;

    assign data  = data_q;
    assign valid = valid_q;
    assign fe    = fe_q;

    // Start needs a high-to-low transition, so after a bad stop bit the line must idle high first.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= RX_IDLE;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            valid_q   <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        bit_q <= 3'd0;
                        state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rx_sync_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            fe_q    <= 1'b0;
                        end else begin
                            fe_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cpu_8bit.sv
// 8-bit accumulator CPU: program loaded over UART while Load=1, executed from PC=0 after Load falls.
module cpu_8bit
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Load,
    input  logic       RX,
    output logic       FE,
    output logic [7:0] Instruction,
    output logic [7:0] Data_mem
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [7:0]    imem_q [MEM_DEPTH];
    logic [7:0]    dmem_q [MEM_DEPTH];
    cpu_state_e    state_q;
    logic          load_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] wp_q;
    logic [7:0]    a_q;
    logic [7:0]    ir_q;
    logic [7:0]    dm_out_q;

    logic [7:0]    rx_data_s;
    logic          rx_valid_s;
    logic          rx_fe_s;
    logic [2:0]    op_s;
    logic [AW-1:0] x_s;
    logic [7:0]    alu_d;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
        .Clk   (Clk),
        .Reset (Reset),
        .RX    (RX),
        .data  (rx_data_s),
        .valid (rx_valid_s),
        .fe    (rx_fe_s)
    );

    assign op_s        = ir_q[7:5];
    assign x_s         = ir_q[AW-1:0];
    assign FE          = rx_fe_s;
    assign Instruction = ir_q;
    assign Data_mem    = dm_out_q;

    // Accumulator next value for the current instruction.
    always_comb begin
        alu_d = a_q;
        alu_d = alu_result(op_s, a_q, dmem_q[x_s], ir_q[4:0]);
    end

    // Control FSM; Load overrides every state, and its rising edge rewinds wp and PC.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= Load ? ST_LOAD : ST_FETCH;
            load_q   <= 1'b0;
            pc_q     <= '0;
            wp_q     <= '0;
            a_q      <= 8'h00;
            ir_q     <= 8'h00;
            dm_out_q <= 8'h00;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                imem_q[i] <= 8'h00;
                dmem_q[i] <= 8'h00;
            end
        end else begin
            load_q <= Load;
            if (Load) begin
                state_q <= ST_LOAD;
                if (!load_q) begin
                    wp_q <= '0;
                    pc_q <= '0;
                end else if (state_q == ST_LOAD && rx_valid_s) begin
                    imem_q[wp_q] <= rx_data_s;
                    ir_q         <= rx_data_s;
                    wp_q         <= wp_q + AW'(1);
                end
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        pc_q    <= '0;
                        state_q <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        ir_q    <= imem_q[pc_q];
                        pc_q    <= pc_q + AW'(1);
                        state_q <= ST_EXEC;
                    end
                    ST_EXEC: begin
                        state_q <= ST_FETCH;
                        case (op_s)
                            OP_HLT: state_q <= ST_HALT;
                            OP_STA: begin
                                dmem_q[x_s] <= a_q;
                                dm_out_q    <= a_q;
                            end
                            OP_JMP: pc_q <= x_s;
                            default: a_q <= alu_d;
                        endcase
                    end
                    ST_HALT: state_q <= ST_HALT;
                    default: state_q <= ST_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_8bit.sv
// Directed and randomized program runs for cpu_8bit, checked against an instruction-level model.
module tb_cpu_8bit;

    localparam int BIT_NS = 96;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Load;
    logic       RX;
    logic       FE;
    logic [7:0] Instruction;
    logic [7:0] Data_mem;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] prog_q[$];
    logic [7:0] m_imem [32];
    logic [7:0] m_dmem [32];
    logic [7:0] m_a;
    logic [7:0] m_dm;
    logic [7:0] m_ir;
    logic       m_halted;

    always #2 Clk = ~Clk;

    cpu_8bit #(.CLKS_PER_BIT(24)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Load        (Load),
        .RX          (RX),
        .FE          (FE),
        .Instruction (Instruction),
        .Data_mem    (Data_mem)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_imem[i] = 8'h00;
            m_dmem[i] = 8'h00;
        end
        m_a = 8'h00;
        m_dm = 8'h00;
        m_ir = 8'h00;
    endtask

    // Instruction-level interpreter; stops at HLT or after a step budget for looping programs.
    task automatic model_run();
        int pc;
        int steps;
        logic [7:0] ir;
        logic [2:0] op;
        int x;
        pc = 0;
        steps = 0;
        m_halted = 1'b0;
        while (!m_halted && steps < 200) begin
            ir = m_imem[pc];
            pc = (pc + 1) % 32;
            op = ir[7:5];
            x  = int'(ir[4:0]);
            case (op)
                3'd0: m_halted = 1'b1;
                3'd1: m_a = m_dmem[x];
                3'd2: m_a = 8'((int'(m_a) + int'(m_dmem[x])) % 256);
                3'd3: m_a = 8'((int'(m_a) - int'(m_dmem[x]) + 256) % 256);
                3'd4: m_a = m_a & m_dmem[x];
                3'd5: begin m_dmem[x] = m_a; m_dm = m_a; end
                3'd6: m_a = 8'(x);
                default: pc = x;
            endcase
            m_ir = ir;
            steps++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        RX = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            #BIT_NS;
        end
        RX = stop_bit;
        #BIT_NS;
        RX = 1'b1;
        #(2 * BIT_NS);
    endtask

    task automatic start_load();
        @(negedge Clk);
        Load = 1'b1;
        repeat (4) @(negedge Clk);
    endtask

    task automatic load_prog();
        start_load();
        for (int i = 0; i < prog_q.size(); i++) begin
            send_byte(prog_q[i], 1'b1);
            m_imem[i % 32] = prog_q[i];
        end
    endtask

    task automatic run_and_check(input string tag, input int cycles);
        @(negedge Clk);
        Load = 1'b0;
        repeat (cycles) @(negedge Clk);
        model_run();
        check({tag, "_dm"}, Data_mem, m_dm);
        if (m_halted) check({tag, "_ir"}, Instruction, m_ir);
        check({tag, "_fe"}, {7'd0, FE}, 8'h00);
    endtask

    task automatic wait_dm(input string tag, input logic [7:0] exp, input int budget);
        int n;
        n = 0;
        while (Data_mem !== exp && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check(tag, Data_mem, exp);
    endtask

    initial begin
        int n;
        logic [7:0] op;
        logic [7:0] x;
        model_reset();
        Reset = 1'b0;
        Load  = 1'b1;
        RX    = 1'b1;
        #11;
        check("rst_ir", Instruction, 8'h00);
        check("rst_dm", Data_mem, 8'h00);
        check("rst_fe", {7'd0, FE}, 8'h00);
        #1;
        Reset = 1'b1;

        prog_q = '{8'h55, 8'hA3, 8'hFF, 8'h00};
        load_prog();
        run_and_check("p1", 60);
        check("p1_ir_const", Instruction, 8'h00);
        check("p1_dm_const", Data_mem, 8'h00);

        prog_q = '{8'hC5, 8'hA2, 8'h00};
        load_prog();
        run_and_check("p2", 60);
        check("p2_dm_const", Data_mem, 8'h05);

        prog_q = '{8'hC3, 8'hA1, 8'h41, 8'h41, 8'hA4, 8'h00};
        load_prog();
        @(negedge Clk);
        Load = 1'b0;
        wait_dm("p3_dm_first", 8'h03, 80);
        wait_dm("p3_dm_second", 8'h09, 80);
        model_run();
        repeat (20) @(negedge Clk);
        check("p3_ir", Instruction, 8'h00);
        check("p3_model_dm", Data_mem, m_dm);

        prog_q = '{8'hC0, 8'hA7, 8'h24, 8'hA7, 8'h00};
        load_prog();
        run_and_check("p3_dmem4", 60);
        check("p3_dmem4_const", Data_mem, 8'h09);

        start_load();
        send_byte(8'hC4, 1'b1);
        m_imem[0] = 8'hC4;
        check("fe_ir_first", Instruction, 8'hC4);
        send_byte(8'hE0, 1'b0);
        check("fe_set", {7'd0, FE}, 8'h01);
        check("fe_ir_kept", Instruction, 8'hC4);
        send_byte(8'hA6, 1'b1);
        m_imem[1] = 8'hA6;
        check("fe_clear", {7'd0, FE}, 8'h00);
        check("fe_ir_next", Instruction, 8'hA6);
        send_byte(8'h00, 1'b1);
        m_imem[2] = 8'h00;
        run_and_check("fe_run", 60);
        check("fe_dm_const", Data_mem, 8'h04);

        prog_q = '{8'hC7, 8'hA1, 8'hE0};
        load_prog();
        @(negedge Clk);
        Load = 1'b0;
        repeat (60) @(negedge Clk);
        model_run();
        check("loop_dm", Data_mem, 8'h07);
        prog_q = '{8'hC9, 8'hA2, 8'h00};
        start_load();
        repeat (40) @(negedge Clk);
        check("loop_stopped_dm", Data_mem, 8'h07);
        send_byte(prog_q[0], 1'b1);
        check("reload_ir", Instruction, 8'hC9);
        send_byte(prog_q[1], 1'b1);
        send_byte(prog_q[2], 1'b1);
        for (int i = 0; i < 3; i++) m_imem[i] = prog_q[i];
        run_and_check("reload", 60);
        check("reload_dm_const", Data_mem, 8'h09);

        for (int p = 0; p < 4; p++) begin
            prog_q.delete();
            n = int'($urandom_range(3, 10));
            for (int k = 0; k < n; k++) begin
                op = 8'($urandom_range(1, 6));
                x  = 8'($urandom_range(0, 31));
                prog_q.push_back({op[2:0], x[4:0]});
            end
            x = 8'($urandom_range(0, 31));
            prog_q.push_back({3'd5, x[4:0]});
            prog_q.push_back(8'h00);
            load_prog();
            run_and_check($sformatf("rnd%0d", p), 60);
        end

        prog_q = '{8'hC8, 8'hA3, 8'hE0};
        load_prog();
        @(negedge Clk);
        Load = 1'b0;
        repeat (50) @(negedge Clk);
        check("pre_rst_dm", Data_mem, 8'h08);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        check("midrst_ir", Instruction, 8'h00);
        check("midrst_dm", Data_mem, 8'h00);
        check("midrst_fe", {7'd0, FE}, 8'h00);
        #5;
        Reset = 1'b1;
        model_reset();

        prog_q = '{8'hC6, 8'hA2};
        load_prog();
        run_and_check("post_rst", 60);
        check("post_rst_dm_const", Data_mem, 8'h06);
        check("post_rst_ir_const", Instruction, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
